// File: rtl/tick_interval_timer.sv
// Programmable interval timer clocked by a one-cycle tick pulse; periodic or one-shot, with hold/stop and pending/overrun status.
// Optional count capture port pair enabled by defining TICK_INTERVAL_TIMER_CAPTURE_EN.
module tick_interval_timer #(
  parameter int W                = 16,
  parameter bit ONE_SHOT_DEFAULT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         one_shot,
  input  logic [W-1:0] period,
  input  logic         ack,
`ifdef TICK_INTERVAL_TIMER_CAPTURE_EN
  input  logic         capture,
  output logic [W-1:0] cap_value,
`endif
  output logic         busy,
  output logic         done_tick,
  output logic         pending,
  output logic         overrun,
  output logic [W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_period;
  logic         r_mode;
  logic [W-1:0] r_count;
  logic         r_busy;
  logic         r_done;
  logic         r_pending;
  logic         r_overrun;

  logic w_terminal;
  logic w_expire;

  assign w_terminal = (r_count == (r_period - W'(1)));
  // Only a tick that survives stop/start/hold priority can expire the interval.
  assign w_expire   = (r_state == S_RUN) && !stop && !start && !hold && tick && w_terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_mode   <= ONE_SHOT_DEFAULT;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start && (period != '0)) begin
          r_state  <= S_RUN;
          r_period <= period;
          r_mode   <= one_shot;
          r_count  <= '0;
          r_busy   <= 1'b1;
        end
      end else if (stop) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (start) begin
        r_count  <= '0;
        r_period <= period;
        r_mode   <= one_shot;
        if (period == '0) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
      end else if (hold) begin
        r_state <= S_HOLD;
      end else if (r_state == S_HOLD) begin
        r_state <= S_RUN;
      end else if (tick) begin
        if (w_terminal) begin
          r_count <= '0;
          r_done  <= 1'b1;
          if (r_mode) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          r_count <= r_count + W'(1);
        end
      end
    end
  end

  // A coincident ack consumes the earlier event, so overrun only reflects expiries after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
      r_overrun <= ack ? 1'b0 : (r_overrun | r_pending);
    end else if (ack) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

`ifdef TICK_INTERVAL_TIMER_CAPTURE_EN
  logic [W-1:0] r_cap;

  // On a terminal tick the registered count still holds period_reg - 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap <= '0;
    end else if (capture) begin
      r_cap <= (r_state == S_IDLE) ? '0 : r_count;
    end
  end

  assign cap_value = r_cap;
`endif

  assign busy      = r_busy;
  assign done_tick = r_done;
  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign count     = r_count;

endmodule

// File: doc/tick_interval_timer.md
Name: tick_interval_timer

Overview:
Programmable interval timer that sits directly downstream of the free-running binary prescale counter and consumes its one-cycle max_tick pulse as a time base. It counts a programmed number of ticks, then raises a done event in either one-shot or periodic mode. It holds a pending/overrun status pair for software or FSM consumers, and it supports hold (pause) and abort.

Parameters:
W, 16, width of period register and tick count
ONE_SHOT_DEFAULT, 0, value of the mode register after reset (0 = periodic, 1 = one-shot)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  time-base pulse from the prescale counter's max_tick; one cycle wide
start  in  1  pulse; latch period/one_shot and begin counting
stop  in  1  pulse; abort and return to IDLE
hold  in  1  level; while high in RUN, ticks are ignored
one_shot  in  1  mode, sampled with start
period  in  W  number of ticks per interval, sampled with start
ack  in  1  pulse; clears pending and overrun
busy  out  1  high in RUN or HOLD
done_tick  out  1  one-cycle pulse at each interval expiry
pending  out  1  sticky; set on expiry
overrun  out  1  sticky; expiry while pending already set
count  out  W  ticks elapsed in current interval

Behaviour:
- Reset (async): state = IDLE; count = 0; period_reg = 0; mode_reg = ONE_SHOT_DEFAULT; done_tick = busy = pending = overrun = 0.
- All outputs are registered; no combinational input-to-output paths.
- States:
  - IDLE: busy = 0, count = 0.
  - RUN: counting.
  - HOLD: frozen.
- IDLE -> RUN on start with period != 0. This latches period_reg = period and mode_reg = one_shot, and sets count = 0.
- start with period == 0 is ignored, and the block stays IDLE.
- RUN -> HOLD when hold = 1. HOLD -> RUN when hold = 0. In HOLD, count is frozen and ticks are dropped, not queued.
- RUN with tick = 1 and hold = 0:
  - if count == period_reg - 1 (terminal): count -> 0 and done_tick = 1 on the next cycle.
  - otherwise count increments by 1.
- After a terminal event:
  - periodic mode stays in RUN.
  - one-shot mode goes to IDLE, and busy falls in the same cycle done_tick rises.
- Latency: the tick on the terminal cycle causes done_tick in the following cycle; the expiry occurs exactly period_reg ticks after start.
- Priority, per cycle, highest first:
  1. stop: state -> IDLE, count -> 0, no done_tick. Applies in RUN or HOLD.
  2. start in RUN or HOLD: restart, reload period/mode, count -> 0, any tick that cycle is ignored. If the new period == 0, treat it as stop.
  3. hold
  4. tick
- A tick arriving in the same cycle as the IDLE -> RUN start is not counted.
- pending is set on each terminal event. overrun is set if a terminal event occurs while pending is already 1.
- ack clears pending and overrun. If ack and a terminal event occur in the same cycle:
  - pending ends at 1.
  - overrun ends at 0 (the ack has consumed the prior event).
- Wrap-around: count never exceeds period_reg - 1, so there is no W-bit overflow. period = 2**W-1 is legal.
- period = 1: every accepted tick is terminal.
- Back-to-back ticks on consecutive cycles are legal and each one is counted.
- Reset asserted mid-interval forces the reset values immediately. No done_tick is emitted.

Optional Feature:
- Macro: TICK_INTERVAL_TIMER_CAPTURE_EN.
- When defined, the block adds two ports:
  - capture (in, 1)
  - cap_value (out, W), reset value 0.
- A capture pulse in RUN or HOLD registers the current count into cap_value on the next cycle. A capture in the same cycle as a terminal tick records period_reg - 1. A capture in IDLE records 0.
- When not defined, the ports and the register do not exist, and all other behaviour is identical.

Test Plan:
- Reset mid-count: period = 10, after 4 ticks assert reset -> count = 0, busy = 0, no done_tick, pending = 0.
- Periodic, period = 5: start, then 15 ticks spaced 3 cycles apart -> done_tick exactly 3 times, each 1 cycle after the 5th/10th/15th tick; busy stays 1; overrun = 1 after the 2nd expiry if there is no ack.
- One-shot, period = 3: start with one_shot = 1, then 4 ticks -> one done_tick after the 3rd tick; state IDLE; the 4th tick leaves count = 0.
- Hold and stop: period = 8, 3 ticks, hold = 1 for 5 ticks, release, 5 ticks -> done after the 8th counted tick (13 total issued). Repeat with stop and a tick in the same cycle at count = 7 -> no done_tick, IDLE.
- Edge values:
  - start with period = 0 -> busy stays 0.
  - period = 1 with 4 back-to-back ticks -> 4 consecutive done_tick pulses.
  - ack coincident with expiry -> pending = 1, overrun = 0.
- With TICK_INTERVAL_TIMER_CAPTURE_EN: period = 6, capture after 4 ticks -> cap_value = 4; capture on the terminal tick -> cap_value = 5.
